motor_pwm_sequencer: RTL and testbench
======================================

# motor_pwm_sequencer

Four-channel motor drive sequencer: it accepts 14-bit duty targets from the CPU-side register interface and slews each channel's applied duty toward its target at a programmable rate. A single shared slew datapath is time-multiplexed across the channels, and the block generates one PWM output per motor. It sits between the processor's motor ports and the motor driver pins.

## Interface
- `W`, 14: duty width (shared with the package).
- `STEP`, 16: maximum duty change per channel per ramp tick; range 1..2^W-1.
- `TICK_DIV`, 5000: clock cycles per ramp tick; must be ≥ 8.

Ports (clock and reset first):
- `clk_clk` in 1: single clock domain for the whole block.
- `reset_reset` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accept; equals `~estop`.
- `cmd_ch` in 2: target channel, 0..3.
- `cmd_target` in W: new duty target.
- `estop` in 1: emergency stop, level-sensitive.
- `pwm_o` out 4: PWM outputs, registered.
- `busy` out 4: `busy[k]` = `cur[k] != target[k]`, registered.
- `cur_duty` out 4*W: applied duties, channel k at bits `[k*W +: W]`.

## Operation
- **Command acceptance.** A command is accepted when `cmd_valid & cmd_ready`; `target[cmd_ch]` is set to `cmd_target`. Commands presented while `estop` is high are dropped.
- **Prescaler.** Counts 0..`TICK_DIV`-1 and wraps. At count `TICK_DIV`-1 it raises `tick` for one cycle.
- **Sweep FSM.** States: IDLE, UPD0, UPD1, UPD2, UPD3.
  - IDLE→UPD0 on `tick`; UPDk→UPDk+1; UPD3→IDLE.
  - `estop` forces IDLE from any state.
- **UPDk slew rule**, computed in W+1 bits so it cannot overflow:
  - if `cur < target`: `cur = min(cur + STEP, target)`.
  - if `cur > target`: `cur = max(cur - STEP, target)`.
  - otherwise `cur` is unchanged.
- **Command during UPDk to channel k.** UPDk uses the old target. The new target is stored and takes effect on the next sweep.
- **PWM.** A W-bit free-running counter `pwm_cnt` wraps from 2^W-1 to 0. `pwm_o[k]` is registered as `pwm_cnt < cur[k]`.
  - Duty 0 → output never high.
  - Duty 2^W-1 → output low for one cycle per period.
- **Estop.** While high, on each clock: all `target` and `cur` are cleared to 0, `pwm_o` = 0, and the FSM goes to IDLE. The prescaler and `pwm_cnt` keep running. After release, operation resumes from zero duties.
- **Reset values.** All `target`, `cur`, prescaler, `pwm_cnt`, `pwm_o` and `busy` are 0; FSM is IDLE. `cmd_ready` follows `estop` and is not gated by reset. Commands are ignored while `reset_reset` is high.

## Timing
- Command accepted at cycle T → `target` visible at T+1. `busy` updates at T+2.
- `tick` at cycle T → UPD0 at T+1 … UPD3 at T+4.
- `cur[k]` changes at the clock edge ending UPDk and is visible on `cur_duty` at T+k+2.
- `pwm_o` reflects `pwm_cnt` and `cur` from the previous cycle (latency 1).
- Sweep length is 5 cycles, shorter than `TICK_DIV`, so a tick never arrives during a sweep.
- `estop` asserted at cycle T → all `cur` = 0 and `pwm_o` = 0 from T+1.
- Reset has priority over `estop`. `estop` has priority over a command in the same cycle.

## Structure
- **Package `motor_seq_pkg`:**
  - `W` and channel count `NCH = 4`.
  - typedef `duty_t` (logic [W-1:0]).
  - enum `sweep_state_t` {IDLE, UPD0, UPD1, UPD2, UPD3}.
- **Sub-module `motor_slew_step`:** purely combinational. Inputs `cur`, `target`, `STEP`; output is the next `cur`. It is instanced once and shared by all channels through the FSM channel mux.

## Test plan
Tests use `STEP=16`, `TICK_DIV=8`.
1. **Reset.** Reset for 3 cycles → all outputs 0; `cmd_ready=1` with `estop` low; a command presented during reset leaves `target` at 0.
2. **Up-ramp.** Command ch0=100 → `cur0` steps 16, 32, 48, 64, 80, 96, 100 on successive sweeps, 8 cycles apart. `busy[0]` drops 1 cycle after `cur0` reaches 100.
3. **Down-ramp.** From `cur3=100`, command ch3=40 → 84, 68, 52, 40, then holds. Other channels are unchanged.
4. **PWM duty.** `cur1=4096` → `pwm_o[1]` is high for exactly 4096 of 16384 cycles per period. Duty 0 is never high. Duty 16383 is high for 16383 cycles per period.
5. **Estop mid-ramp.** Pulse `estop` during UPD1 → next cycle all `cur`=0, `pwm_o`=0, `cmd_ready`=0, and a command during estop is dropped. After release, command ch1=32 ramps 16, 32.
6. **Write collision.** Command ch2=200 (old target 50, `cur2=40`) in the UPD2 cycle → `cur2` becomes 50 this sweep, then 66 on the next sweep.

Source files
------------

// File: rtl/motor_pwm_sequencer_pkg.sv
// Shared types and constants for the four-channel motor PWM sequencer.
package motor_seq_pkg;

    localparam int unsigned W   = 14;
    localparam int unsigned NCH = 4;

    typedef logic [W-1:0] duty_t;

    typedef enum logic [2:0] {
        IDLE,
        UPD0,
        UPD1,
        UPD2,
        UPD3
    } sweep_state_t;

    // Channel serviced by the shared slew datapath in a given sweep state.
    function automatic logic [1:0] upd_ch(sweep_state_t s);
        case (s)
            UPD1:    return 2'd1;
            UPD2:    return 2'd2;
            UPD3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/motor_pwm_sequencer_if.sv
// CPU-side command port of the motor PWM sequencer.
interface motor_pwm_sequencer_if;
    import motor_seq_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    duty_t      cmd_target;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_target,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_target,
        output cmd_ready
    );

endinterface

// File: rtl/motor_pwm_sequencer_slew_step.sv
// One slew step: moves cur toward target by at most STEP without overshoot.
module motor_slew_step
    import motor_seq_pkg::*;
#(
    parameter int unsigned STEP = 16
) (
    input  duty_t cur,
    input  duty_t target,
    output duty_t cur_next
);

    localparam int unsigned WX = W + 1;
    localparam logic [W:0] STEP_X = WX'(STEP);

    logic [W:0] up_sum;
    logic [W:0] dn_diff;

    assign up_sum  = {1'b0, cur} + STEP_X;
    assign dn_diff = {1'b0, cur} - STEP_X;

    // A borrow out of the subtraction sets dn_diff[W], meaning we went below zero.
    always_comb begin
        cur_next = cur;
        if (cur < target) begin
            cur_next = (up_sum > {1'b0, target}) ? target : up_sum[W-1:0];
        end else if (cur > target) begin
            cur_next = (dn_diff[W] || (dn_diff[W-1:0] < target)) ? target : dn_diff[W-1:0];
        end
    end

endmodule

// File: rtl/motor_pwm_sequencer.sv
// Four-channel duty slew sequencer with a time-multiplexed slew datapath and PWM outputs.
module motor_pwm_sequencer
    import motor_seq_pkg::*;
#(
    parameter int unsigned STEP     = 16,
    parameter int unsigned TICK_DIV = 5000
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    motor_pwm_sequencer_if.slave cmd,
    input  logic                 estop,
    output logic [NCH-1:0]       pwm_o,
    output logic [NCH-1:0]       busy,
    output logic [NCH*W-1:0]     cur_duty
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]    presc;
    logic             tick;
    duty_t            pwm_cnt;
    duty_t [NCH-1:0]  target;
    duty_t [NCH-1:0]  cur;
    sweep_state_t     state;
    logic [1:0]       sel;
    duty_t            slew_next;
    logic             accept;

    assign cmd.cmd_ready = ~estop;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready & ~reset_reset;
    assign tick          = (presc == PW'(TICK_DIV - 1));
    assign sel           = upd_ch(state);
    assign cur_duty      = cur;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + duty_t'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset || estop) begin
            target <= '0;
        end else if (accept) begin
            target[cmd.cmd_ch] <= cmd.cmd_target;
        end
    end

    motor_slew_step #(
        .STEP (STEP)
    ) u_slew (
        .cur      (cur[sel]),
        .target   (target[sel]),
        .cur_next (slew_next)
    );

    // Target writes in the same cycle land after this edge, so UPDk slews toward the old target.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || estop) begin
            state <= IDLE;
            cur   <= '0;
        end else begin
            case (state)
                IDLE:    state <= tick ? UPD0 : IDLE;
                UPD0:    state <= UPD1;
                UPD1:    state <= UPD2;
                UPD2:    state <= UPD3;
                default: state <= IDLE;
            endcase
            if (state != IDLE) begin
                cur[sel] <= slew_next;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pwm_o <= '0;
            busy  <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                busy[k]  <= (cur[k] != target[k]);
                pwm_o[k] <= ~estop & (pwm_cnt < cur[k]);
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// Randomized bench for motor_pwm_sequencer against a cycle-count based reference model.
module tb_motor_pwm_sequencer;
    import motor_seq_pkg::*;

    localparam int STEP_T = 16;
    localparam int TDIV   = 8;
    localparam int PERIOD = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        estop;
    logic [3:0]  pwm_o;
    logic [3:0]  busy;
    logic [55:0] cur_duty;

    motor_pwm_sequencer_if cmd_bus ();

    motor_pwm_sequencer #(
        .STEP     (STEP_T),
        .TICK_DIV (TDIV)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .cmd         (cmd_bus),
        .estop       (estop),
        .pwm_o       (pwm_o),
        .busy        (busy),
        .cur_duty    (cur_duty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: duties as plain integers, sweep timing from cycle counts since reset.
    int m_tgt[4];
    int m_cur[4];
    int m_busy[4];
    int m_pwm[4];
    int m_cyc;
    int m_tick;
    int m_pcnt;
    int hi_cnt[4];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    function automatic int slew(int c, int t);
        if (c < t) return (c + STEP_T < t) ? c + STEP_T : t;
        if (c > t) return (c - STEP_T > t) ? c - STEP_T : t;
        return c;
    endfunction

    function automatic int sweep_pos();
        return m_cyc - m_tick - 1;
    endfunction

    task automatic run_cycle(input bit r, input bit e, input bit v, input int ch, input int tg);
        int          n_tgt[4];
        int          n_cur[4];
        int          k;
        logic [55:0] exp_cur;
        logic [3:0]  exp_pwm;
        logic [3:0]  exp_busy;
        rst                = r;
        estop              = e;
        cmd_bus.cmd_valid  = v;
        cmd_bus.cmd_ch     = 2'(ch);
        cmd_bus.cmd_target = 14'(tg);
        n_tgt = m_tgt;
        n_cur = m_cur;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                n_tgt[i] = 0; n_cur[i] = 0; m_busy[i] = 0; m_pwm[i] = 0;
            end
            m_cyc = 0; m_tick = -100; m_pcnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] = (m_cur[i] != m_tgt[i]) ? 1 : 0;
                m_pwm[i]  = (!e && m_pcnt < m_cur[i]) ? 1 : 0;
            end
            if (e) begin
                for (int i = 0; i < 4; i++) begin
                    n_tgt[i] = 0; n_cur[i] = 0;
                end
                m_tick = -100;
            end else begin
                k = sweep_pos();
                if (k >= 0 && k < 4) n_cur[k] = slew(m_cur[k], m_tgt[k]);
                if (v) n_tgt[ch] = tg;
                if (m_cyc % TDIV == TDIV - 1) m_tick = m_cyc;
            end
            m_pcnt = (m_pcnt + 1) % PERIOD;
            m_cyc++;
        end
        @(posedge clk);
        #1;
        m_tgt = n_tgt;
        m_cur = n_cur;
        for (int i = 0; i < 4; i++) begin
            exp_cur[i*14 +: 14] = m_cur[i][13:0];
            exp_pwm[i]          = m_pwm[i][0];
            exp_busy[i]         = m_busy[i][0];
            hi_cnt[i]          += int'(pwm_o[i]);
        end
        check_val("cur_duty", 64'(cur_duty), 64'(exp_cur));
        check_val("pwm_o", 64'(pwm_o), 64'(exp_pwm));
        check_val("busy", 64'(busy), 64'(exp_busy));
        check_val("cmd_ready", 64'(cmd_bus.cmd_ready), 64'(!e));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        int t3;
        int tries;
        logic [13:0] ch2_duty;
        rst = 1'b1;
        estop = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_ch = 2'd0;
        cmd_bus.cmd_target = '0;
        for (int i = 0; i < 4; i++) begin
            m_tgt[i] = 0; m_cur[i] = 0; hi_cnt[i] = 0;
        end

        // Reset with commands presented; they must leave targets at zero.
        for (int i = 0; i < 3; i++)
            run_cycle(1, 0, 1, int'($urandom_range(0, 3)), int'($urandom_range(1, 16383)));
        idle(4);

        // Up-ramp on ch0, then down-ramp on ch3.
        run_cycle(0, 0, 1, 0, 100);
        idle(70);
        run_cycle(0, 0, 1, 3, 100);
        idle(60);
        run_cycle(0, 0, 1, 3, 40);
        idle(40);

        // Estop landing in the UPD1 cycle, with a command during estop that must be dropped.
        run_cycle(0, 0, 1, 1, 300);
        idle(10);
        tries = 0;
        while (sweep_pos() != 1 && tries < 16) begin
            idle(1);
            tries++;
        end
        run_cycle(0, 1, 1, 1, 500);
        run_cycle(0, 0, 1, 1, 32);
        idle(30);

        // Write collision on ch2 in its UPD2 cycle.
        run_cycle(0, 0, 1, 2, 40);
        idle(40);
        tries = 0;
        while (sweep_pos() != 3 && tries < 16) begin
            idle(1);
            tries++;
        end
        run_cycle(0, 0, 1, 2, 50);
        tries = 0;
        while (sweep_pos() != 2 && tries < 16) begin
            idle(1);
            tries++;
        end
        run_cycle(0, 0, 1, 2, 200);
        ch2_duty = cur_duty[28 +: 14];
        check_val("collision_cur2", 64'(ch2_duty), 64'd50);
        idle(8);
        ch2_duty = cur_duty[28 +: 14];
        check_val("collision_next", 64'(ch2_duty), 64'd66);
        idle(40);

        // Randomized commands and rare estops.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_cycle(0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 16383)));
            else
                run_cycle(0, ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 300)));
        end

        // PWM duty over one full period at 0, 4096, full-scale and a random duty.
        t3 = int'($urandom_range(1, 16382));
        run_cycle(0, 0, 1, 0, 0);
        run_cycle(0, 0, 1, 1, 4096);
        run_cycle(0, 0, 1, 2, 16383);
        run_cycle(0, 0, 1, 3, t3);
        idle(8300);
        for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
        idle(PERIOD);
        check_val("hi_cnt0", 64'(hi_cnt[0]), 64'd0);
        check_val("hi_cnt1", 64'(hi_cnt[1]), 64'd4096);
        check_val("hi_cnt2", 64'(hi_cnt[2]), 64'd16383);
        check_val("hi_cnt3", 64'(hi_cnt[3]), 64'(t3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
